seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display, the parametrised successor to the single-digit BCD-to-7-segment decoder. It scans one digit per refresh slot, decodes a 4-bit nibble per digit to active-low segments, and supports hex/decimal modes, leading-zero blanking, per-digit decimal points and anti-ghosting blanking. Displayed data is double-buffered and swapped only at frame boundaries, so the display never shows a torn value. It sits between user logic and the board's AN/segment pins.

## Interface
- NUM_DIGITS, 4, number of digits (1..8)
- REFRESH_DIV, 100000, clock cycles per digit slot (≥ 4)
- BLANK_CYCLES, 4, cycles at slot start with all anodes off (1 ≤ BLANK_CYCLES < REFRESH_DIV)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  1 = display on; 0 = all anodes off, scanning continues
- load  in  1  single-cycle strobe that captures value/dp_mask into staging
- value  in  4*NUM_DIGITS  nibble i drives digit i (digit 0 = rightmost)
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i
- dec_mode  in  1  1 = nibbles > 9 shown as dash (g only)
- lz_blank  in  1  1 = suppress leading zeros
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while lit
- frame_tick  out  1  one-cycle pulse at the start of each frame

## Operation
- Slot counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle in which the index wraps to 0. frame_tick pulses in that cycle.
- Staging register and pending flag:
  - load writes staging and sets pending. A second load before the boundary overwrites staging; the last load wins.
  - At the frame boundary, if pending is set, staging copies into the display register and pending clears.
  - If load coincides with a frame boundary, the display takes the old staging contents and the new data stays pending until the next boundary.
- Font (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dash=0111111, blank=1111111
- Leading-zero blanking: digit i > 0 is blanked (seg=1111111, dp_n=1) when lz_blank=1 and every display nibble from NUM_DIGITS-1 down to i is 0. Digit 0 is never blanked. A blanked digit still has its anode driven.
- Anti-ghosting: an is all 1 while the slot counter < BLANK_CYCLES.
- en=0: an is all 1. seg, dp_n, counters and buffering continue unaffected.

## Timing
- seg, dp_n, an and frame_tick are registered: they reflect the counter/index state one cycle later.
- Reset is asynchronous and takes effect immediately, including mid-frame. Reset values:
  - slot counter = 0, index = 0
  - staging = 0, display = 0, pending = 0
  - an = all 1, seg = 1111111, dp_n = 1, frame_tick = 0
- After reset release, digit 0's anode asserts at cycle BLANK_CYCLES+1.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-BLANK_CYCLES cycles per frame.
- Load-to-visible latency: at most one frame period plus 1 cycle.

## Structure
- Package seg7_pkg holds:
  - the 16 hex font constants plus SEG_DASH and SEG_BLANK (7-bit, active-low)
  - the bit-order definition for seg
- Sub-module hex7seg_decode: combinational; inputs nibble, dec_mode, blank; output 7-bit seg. Instantiated once, fed by the index mux.
- The top level contains the slot counter, index register, staging/display registers, leading-zero logic and output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then load value=16'h1234 → from the second frame, an cycles 1110, 1101, 1011, 0111. seg matches 4, 3, 2, 1 respectively. an=1111 for the first 2 cycles of each slot.
- Load 16'hABCD, then load 16'h5678 in the same frame → the next frame shows 5678. ABCD never appears.
- Load issued in the frame_tick cycle → the display shows the old staging data for that frame and the new value the frame after.
- dec_mode=1, value=16'h0A19 → digit 1 seg=1111001 (1), digit 2 seg=0111111 (dash).
- lz_blank=1, value=16'h0005 → digits 3..1 seg=1111111, digit 0 seg=0010010. With value=16'h0000, only digit 0 shows 1000000.
- rst_n asserted mid-slot with en=1 → an=1111 and seg=1111111 in the same cycle, without waiting for a clock edge. After release the scan restarts at digit 0 with display=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared font table and segment encoding for the 7-segment scan driver.
// seg bit order is {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a), active-low.
package seg7_pkg;

  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t HEX_FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Nibble to active-low segment decoder; blank overrides, decimal mode dashes 10..15.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dec_mode_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = HEX_FONT[nibble_i];
    if (dec_mode_i && (nibble_i > 4'd9)) seg_o = SEG_DASH;
    if (blank_i) seg_o = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-aligned
// double buffering, leading-zero blanking and anti-ghosting slot blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    dec_mode,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(REFRESH_DIV - 2);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] stg_q, disp_q;
  logic [NUM_DIGITS-1:0] stg_dp_q, disp_dp_q;
  logic pend_q, pend_d;

  logic slot_end, boundary, pre_boundary;
  logic [NUM_DIGITS-1:0] lz_run;
  logic run, blank_sel;
  seg_t seg_dec;

  assign slot_end     = (cnt_q == CNT_LAST);
  assign boundary     = slot_end && (idx_q == IDX_LAST);
  // Decoded one cycle early so the registered tick lines up with the boundary cycle.
  assign pre_boundary = (cnt_q == CNT_PRE) && (idx_q == IDX_LAST);

  assign cnt_d  = slot_end ? '0 : cnt_q + CW'(1);
  assign idx_d  = !slot_end ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + IW'(1));
  assign pend_d = load | (pend_q & ~boundary);

  always_comb begin
    run    = 1'b1;
    lz_run = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run       = run & (disp_q[i] == 4'd0);
      lz_run[i] = run;
    end
  end

  assign blank_sel = lz_blank && (idx_q != '0) && lz_run[idx_q];

  hex7seg_decode u_dec (
    .nibble_i  (disp_q[idx_q]),
    .dec_mode_i(dec_mode),
    .blank_i   (blank_sel),
    .seg_o     (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      stg_q      <= '0;
      stg_dp_q   <= '0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      pend_q     <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      if (load) begin
        stg_q    <= value;
        stg_dp_q <= dp_mask;
      end
      // A load in the boundary cycle stays pending; display takes the older staging.
      if (boundary && pend_q) begin
        disp_q    <= stg_q;
        disp_dp_q <= stg_dp_q;
      end
      an         <= (en && (cnt_q >= CNT_BLANK)) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg        <= seg_dec;
      dp_n       <= ~(disp_dp_q[idx_q] & ~blank_sel);
      frame_tick <= pre_boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus pushes per-frame digit expectations, monitor pops on each lit slot.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] F0  = 7'b1000000, F1 = 7'b1111001, F2 = 7'b0100100, F3 = 7'b0110000;
  localparam logic [6:0] F4  = 7'b0011001, F5 = 7'b0010010, F6 = 7'b0000010, F7 = 7'b1111000;
  localparam logic [6:0] F8  = 7'b0000000, F9 = 7'b0010000, FA = 7'b0001000, FF = 7'b0001110;
  localparam logic [6:0] DSH = 7'b0111111, BLK = 7'b1111111;

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, load = 1'b0, dec_mode = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;

  typedef struct {
    int         frame;
    int         dig;
    logic [6:0] seg;
    logic       dpn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0;
  int fn = 0, since_tick = 0, run_len = 0, dig = 0;
  logic prev_lit = 1'b0;
  logic [3:0] exp_an;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
    .dec_mode(dec_mode), .lz_blank(lz_blank), .seg(seg), .dp_n(dp_n), .an(an),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    sb.push_back('{f, 0, s0, dpn[0]});
    sb.push_back('{f, 1, s1, dpn[1]});
    sb.push_back('{f, 2, s2, dpn[2]});
    sb.push_back('{f, 3, s3, dpn[3]});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_mask = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    logic ok = 1'b0;
    for (int i = 0; i < RD*ND + 4; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin ok = 1'b1; break; end
    end
    chk("frame_tick_seen", 32'(ok), 1);
    #1;
  endtask

  task automatic release_checks();
    @(negedge clk); chk("post_rst_an_c1", 32'(an), 4'hF);
    @(negedge clk); chk("post_rst_an_c2", 32'(an), 4'hF);
    @(negedge clk);
    chk("post_rst_an_c3", 32'(an), 4'hE);
    chk("post_rst_seg",   32'(seg), F0);
    chk("post_rst_dpn",   32'(dp_n), 1);
  endtask

  // Monitor: each time a digit lights, pop the expectation for the current frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      fn = 0; since_tick = 0; prev_lit = 1'b0; run_len = 0;
    end else begin
      if (frame_tick) begin fn++; since_tick = 0; end
      else since_tick++;
      if (an != 4'hF) begin
        if (!prev_lit) begin
          dig = -1;
          for (int i = 0; i < ND; i++) if (an == ~(4'b1 << i)) dig = i;
          if (dig == 0 && fn > 0) chk("tick_to_digit0", since_tick, BC + 2);
          while (sb.size() > 0 && sb[0].frame < fn) begin
            chk($sformatf("missed f%0d d%0d", sb[0].frame, sb[0].dig), fn, sb[0].frame);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].frame == fn) begin
            e = sb.pop_front();
            exp_an = ~(4'b1 << e.dig);
            chk($sformatf("an f%0d d%0d", e.frame, e.dig),  32'(an),   32'(exp_an));
            chk($sformatf("seg f%0d d%0d", e.frame, e.dig), 32'(seg),  32'(e.seg));
            chk($sformatf("dpn f%0d d%0d", e.frame, e.dig), 32'(dp_n), 32'(e.dpn));
          end
          run_len = 1;
        end else begin
          run_len++;
        end
        prev_lit = 1'b1;
      end else begin
        if (prev_lit) chk("lit_len", run_len, RD - BC);
        prev_lit = 1'b0;
      end
    end
  end

  initial begin
    logic ok;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_an",   32'(an), 4'hF);
    chk("rst_seg",  32'(seg), BLK);
    chk("rst_dpn",  32'(dp_n), 1);
    chk("rst_tick", 32'(frame_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    release_checks();

    do_load(16'h1234, 4'b0100);
    push_frame(1, F4, F3, F2, F1, 4'b1011);
    wait_tick();

    do_load(16'hABCD, 4'b1111);
    do_load(16'h5678, 4'b0000);
    push_frame(2, F8, F7, F6, F5, 4'hF);
    wait_tick();

    do_load(16'h00F1, 4'b1000);
    wait_tick();
    push_frame(3, F1, FF, F0, F0, 4'b0111);
    push_frame(4, F9, F1, FA, F0, 4'hF);
    do_load(16'h0A19, 4'b0000);
    wait_tick();

    push_frame(5, F9, F1, DSH, F0, 4'hF);
    wait_tick();
    dec_mode = 1'b1;
    do_load(16'h0005, 4'b0000);
    push_frame(6, F5, BLK, BLK, BLK, 4'hF);
    wait_tick();

    dec_mode = 1'b0;
    lz_blank = 1'b1;
    do_load(16'h0000, 4'b1111);
    push_frame(7, F0, BLK, BLK, BLK, 4'b1110);
    wait_tick();

    do_load(16'h0008, 4'b0001);
    sb.push_back('{8, 0, F8, 1'b0});
    wait_tick();
    lz_blank = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an == 4'hE) begin ok = 1'b1; break; end
    end
    chk("digit0_lit_before_reset", 32'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an",   32'(an), 4'hF);
    chk("mid_rst_seg",  32'(seg), BLK);
    chk("mid_rst_dpn",  32'(dp_n), 1);
    chk("mid_rst_tick", 32'(frame_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    release_checks();
    push_frame(1, F0, F0, F0, F0, 4'hF);
    wait_tick();
    wait_tick();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
